spm_seq_ctrl: RTL and testbench
===============================

Name: spm_seq_ctrl

Overview:
- Sequencer for the serial-parallel multiplier (spm) carry-save datapath.
- Accepts a multiplicand/multiplier pair over a valid/ready request port and holds the multiplicand on the parallel x bus.
- Streams the multiplier LSB-first on the serial y line and clears the csa chain before each operation.
- Deserialises the serial product bit into a 2*WIDTH result returned over a valid/ready response port.

Parameters:
- WIDTH, 32, operand width in bits; must equal the spm array size.
- DP_LAT, 1, cycles from driving a y bit to its product bit appearing on spm_p.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready.
- req_mc  in  WIDTH  multiplicand.
- req_mp  in  WIDTH  multiplier.
- spm_x  out  WIDTH  parallel multiplicand to the datapath.
- spm_y  out  1  serial multiplier bit to the datapath.
- spm_clr  out  1  synchronous clear of the datapath csa registers, active-high.
- spm_p  in  1  serial product bit from the datapath.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result ready.
- rsp_prod  out  2*WIDTH  product.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst=0), immediate regardless of clock:
  - state=IDLE, counter=0, all registers cleared.
  - req_ready=0 while rst=0, then 1 from the first cycle after rst deasserts.
  - spm_x=0, spm_y=0, spm_clr=0, rsp_valid=0, rsp_prod=0, busy=0.
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch req_mc into the spm_x register and req_mp into the mp shift register; go to CLEAR.
- CLEAR:
  - Exactly one cycle with spm_clr=1 and spm_y=0; counter cleared to 0; go to RUN.
- RUN:
  - Counter k runs 0..2*WIDTH+DP_LAT-1; counter width is $clog2(2*WIDTH+DP_LAT+1).
  - spm_y = mp bit k for k<WIDTH, else 0 (unsigned zero extension).
  - For k>=DP_LAT: prod <= {spm_p, prod[2*WIDTH-1:1]}, i.e. exactly 2*WIDTH captures.
  - After the k=2*WIDTH+DP_LAT-1 cycle, go to DONE.
- DONE:
  - rsp_valid=1 and rsp_prod held stable until rsp_valid&&rsp_ready, then go to IDLE.
  - rsp_valid must not drop before the handshake; rsp_prod must not change while rsp_valid=1.
- Latency: with the accept edge at cycle 0, rsp_valid rises in cycle 2*WIDTH+DP_LAT+2.
  - WIDTH=8, DP_LAT=1 gives rsp_valid in cycle 19.
- Throughput:
  - No request is accepted outside IDLE (req_ready=0). req_valid while busy is held off, not dropped.
  - Earliest next accept is the cycle after the response handshake; no response/request overlap.
- spm_x is stable from CLEAR through DONE. It changes only on accept or reset.
- rsp_prod is registered; its value outside DONE is don't-care for checkers.
- Reset mid-operation: abandons the operation, no response is produced, FSM returns to IDLE.
- rsp_ready asserted outside DONE: ignored.

Optional Feature:
- Macro: SPM_SEQ_CTRL_PERF_EN.
- Enabled:
  - Adds output op_count (16 bits): incremented on each response handshake, saturating at 0xFFFF.
  - Adds output stall_count (16 bits): incremented each DONE cycle with rsp_ready=0, saturating at 0xFFFF.
  - Both reset to 0 on rst=0.
- Disabled: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- WIDTH=8, DP_LAT=1, reference spm model attached:
  - req_mc=0x0F, req_mp=0x11 -> rsp_prod=0x00FF.
  - rsp_valid rises in cycle 19 after accept; spm_clr high exactly in cycle 1.
- req_mc=0xFF, req_mp=0xFF -> rsp_prod=0xFE01; operand 0x00 with 0xA5 -> rsp_prod=0x0000.
- Response backpressure:
  - Hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid and rsp_prod=0x1234-stable product held unchanged.
  - Handshake on the 6th cycle; req_ready=1 in the following cycle.
- req_valid held high with new operands during RUN -> req_ready=0 throughout, no corruption of spm_x or the product; request accepted only after return to IDLE.
- Drop rst=0 at RUN k=5, release after 2 cycles:
  - All outputs at reset values immediately; no rsp_valid.
  - Next request 0x03*0x05 -> 0x000F.
- With SPM_SEQ_CTRL_PERF_EN, three back-to-back operations, 4 stall cycles on the second -> op_count=3, stall_count=4.

Source files
------------

// File: rtl/spm_seq_ctrl.sv
// Sequencer for the serial-parallel multiplier carry-save datapath.
// Holds the multiplicand on spm_x, streams the multiplier LSB-first on spm_y,
// clears the csa chain before each operation and deserialises spm_p into a
// 2*WIDTH product returned over a valid/ready response port.
// Optional macro SPM_SEQ_CTRL_PERF_EN adds op_count and stall_count outputs.
module spm_seq_ctrl #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned DP_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [WIDTH-1:0]     req_mc,
   input  logic [WIDTH-1:0]     req_mp,
   output logic [WIDTH-1:0]     spm_x,
   output logic                 spm_y,
   output logic                 spm_clr,
   input  logic                 spm_p,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [2*WIDTH-1:0]   rsp_prod,
`ifdef SPM_SEQ_CTRL_PERF_EN
   output logic [15:0]          op_count,
   output logic [15:0]          stall_count,
`endif
   output logic                 busy
);

   localparam int unsigned CntW = $clog2(2*WIDTH + DP_LAT + 1);
   localparam logic [CntW-1:0] LastCnt  = CntW'(2*WIDTH + DP_LAT - 1);
   localparam logic [CntW-1:0] CapStart = CntW'(DP_LAT);

   typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

   state_e              r_state;
   logic [CntW-1:0]     r_cnt;
   logic                r_armed;
   logic [WIDTH-1:0]    r_x;
   logic [WIDTH-1:0]    r_mp;
   logic                r_y;
   logic                r_clr;
   logic                r_rsp_valid;
   logic [2*WIDTH-1:0]  r_prod;

   logic                w_req_ready;
   logic                w_rsp_hs;

   // r_armed keeps req_ready low while reset is held and until the first edge after release
   assign w_req_ready = r_armed && (r_state == StIdle);
   assign w_rsp_hs    = r_rsp_valid && rsp_ready;

   assign req_ready = w_req_ready;
   assign spm_x     = r_x;
   assign spm_y     = r_y;
   assign spm_clr   = r_clr;
   assign rsp_valid = r_rsp_valid;
   assign rsp_prod  = r_prod;
   assign busy      = (r_state != StIdle);

   // Main sequencer FSM with registered datapath controls
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_armed     <= 1'b0;
         r_x         <= '0;
         r_mp        <= '0;
         r_y         <= 1'b0;
         r_clr       <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_prod      <= '0;
      end else begin
         r_armed <= 1'b1;
         unique case (r_state)
            StIdle: begin
               if (req_valid && w_req_ready) begin
                  r_x     <= req_mc;
                  r_mp    <= req_mp;
                  r_clr   <= 1'b1;
                  r_state <= StClear;
               end
            end
            StClear: begin
               // Preload bit 0 so it is on spm_y during the k=0 cycle
               r_clr   <= 1'b0;
               r_cnt   <= '0;
               r_y     <= r_mp[0];
               r_mp    <= r_mp >> 1;
               r_state <= StRun;
            end
            StRun: begin
               // Product bits trail y bits by DP_LAT cycles
               if (r_cnt >= CapStart) begin
                  r_prod <= {spm_p, r_prod[2*WIDTH-1:1]};
               end
               if (r_cnt == LastCnt) begin
                  r_y         <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= StDone;
               end else begin
                  // Shifting in zeros gives the unsigned zero extension past WIDTH
                  r_cnt <= r_cnt + CntW'(1);
                  r_y   <= r_mp[0];
                  r_mp  <= r_mp >> 1;
               end
            end
            StDone: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

`ifdef SPM_SEQ_CTRL_PERF_EN
   logic [15:0] r_op_count;
   logic [15:0] r_stall_count;

   assign op_count    = r_op_count;
   assign stall_count = r_stall_count;

   // Saturating handshake and backpressure counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_op_count    <= '0;
         r_stall_count <= '0;
      end else begin
         if (w_rsp_hs && (r_op_count != 16'hFFFF)) begin
            r_op_count <= r_op_count + 16'd1;
         end
         if (r_rsp_valid && !rsp_ready && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
         end
      end
   end
`else
   logic w_unused_hs;
   assign w_unused_hs = w_rsp_hs;
`endif

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Self-checking bench for spm_seq_ctrl with a behavioural spm datapath model
// (one cycle from spm_y to spm_p) and a product scoreboard.
module tb_spm_seq_ctrl;

   localparam int W   = 8;
   localparam int DL  = 1;
   localparam int LAT = 2*W + DL + 2;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           req_valid = 1'b0;
   logic           req_ready;
   logic [W-1:0]   req_mc = '0;
   logic [W-1:0]   req_mp = '0;
   logic [W-1:0]   spm_x;
   logic           spm_y;
   logic           spm_clr;
   logic           spm_p;
   logic           rsp_valid;
   logic           rsp_ready = 1'b0;
   logic [2*W-1:0] rsp_prod;
   logic           busy;
`ifdef SPM_SEQ_CTRL_PERF_EN
   logic [15:0]    op_count;
   logic [15:0]    stall_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [2*W-1:0] exp_q[$];

   spm_seq_ctrl #(.WIDTH(W), .DP_LAT(DL)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_mc     (req_mc),
      .req_mp     (req_mp),
      .spm_x      (spm_x),
      .spm_y      (spm_y),
      .spm_clr    (spm_clr),
      .spm_p      (spm_p),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_prod   (rsp_prod),
`ifdef SPM_SEQ_CTRL_PERF_EN
      .op_count   (op_count),
      .stall_count(stall_count),
`endif
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Behavioural serial-parallel multiplier: accumulate x*y, emit LSB, shift
   logic [63:0] acc = '0;
   logic        p_q = 1'b0;
   logic [63:0] sum;
   assign sum   = acc + (spm_y ? {56'd0, spm_x} : 64'd0);
   assign spm_p = p_q;
   always @(posedge clk) begin
      if (spm_clr) begin
         acc <= '0;
         p_q <= 1'b0;
      end else begin
         acc <= sum >> 1;
         p_q <= sum[0];
      end
   end

   task automatic do_op(input logic [W-1:0] mc, input logic [W-1:0] mp, input int stall,
                        input bit check_lat, input bit hold,
                        input logic [W-1:0] nmc, input logic [W-1:0] nmp);
      int edges;
      bit bad_run;
      bit bad_clr;
      logic [2*W-1:0] held;
      logic [2*W-1:0] exp;
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL op_ready_idle: got %b expected 1", req_ready);
      end
      req_mc = mc;
      req_mp = mp;
      req_valid = 1'b1;
      exp_q.push_back({8'd0, mc} * {8'd0, mp});
      @(posedge clk); #1;
      if (hold) begin
         req_mc = nmc;
         req_mp = nmp;
      end else begin
         req_valid = 1'b0;
      end
      n_checks++;
      if (spm_clr !== 1'b1 || spm_y !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_cycle: got clr=%b y=%b expected clr=1 y=0", spm_clr, spm_y);
      end
      edges = 0;
      bad_run = 1'b0;
      bad_clr = 1'b0;
      while (rsp_valid !== 1'b1 && edges < 200) begin
         if (req_ready !== 1'b0 || spm_x !== mc || busy !== 1'b1) bad_run = 1'b1;
         @(posedge clk); #1;
         edges++;
         if (spm_clr !== 1'b0) bad_clr = 1'b1;
      end
      n_checks++;
      if (bad_run || bad_clr) begin
         n_fail++;
         $display("FAIL run_stable: got bad_run=%b bad_clr=%b expected 0 0", bad_run, bad_clr);
      end
      n_checks++;
      if (rsp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rsp_timeout: got rsp_valid=%b expected 1", rsp_valid);
         void'(exp_q.pop_front());
         return;
      end
      if (check_lat) begin
         n_checks++;
         if (edges + 1 != LAT) begin
            n_fail++;
            $display("FAIL latency: got cycle %0d expected cycle %0d", edges + 1, LAT);
         end
      end
      held = rsp_prod;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (rsp_valid !== 1'b1 || rsp_prod !== held || spm_x !== mc) begin
            n_fail++;
            $display("FAIL stall_hold: got valid=%b prod=%h expected valid=1 prod=%h",
                     rsp_valid, rsp_prod, held);
         end
      end
      exp = exp_q.pop_front();
      n_checks++;
      if (rsp_prod !== exp) begin
         n_fail++;
         $display("FAIL product %h*%h: got %h expected %h", mc, mp, rsp_prod, exp);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL post_handshake: got valid=%b ready=%b busy=%b expected 0 1 0",
                  rsp_valid, req_ready, busy);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      n_checks++;
      if (req_ready !== 1'b0 || spm_x !== '0 || spm_y !== 1'b0 || spm_clr !== 1'b0 ||
          rsp_valid !== 1'b0 || rsp_prod !== '0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: got rdy=%b x=%h y=%b clr=%b v=%b p=%h busy=%b expected all 0",
                  tag, req_ready, spm_x, spm_y, spm_clr, rsp_valid, rsp_prod, busy);
      end
   endtask

   task automatic release_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      n_checks++;
      if (req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_before_edge: got %b expected 0", req_ready);
      end
      @(posedge clk); #1;
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_release: got %b expected 1", req_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #2;
      check_reset_outputs("reset_state");
      @(posedge clk); #1;
      check_reset_outputs("reset_held");
      release_reset();
   endtask

   task automatic test_basic();
      do_op(8'h0F, 8'h11, 0, 1'b1, 1'b0, '0, '0);
      do_op(8'hFF, 8'hFF, 0, 1'b1, 1'b0, '0, '0);
      do_op(8'h00, 8'hA5, 0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic test_backpressure();
      // 0x14 * 0xE9 = 0x1234
      do_op(8'h14, 8'hE9, 5, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic test_holdoff();
      do_op(8'h5A, 8'h3C, 0, 1'b1, 1'b1, 8'hC3, 8'h77);
      do_op(8'hC3, 8'h77, 0, 1'b1, 1'b0, '0, '0);
   endtask

   task automatic test_reset_mid_op();
      req_mc = 8'hAB;
      req_mp = 8'hCD;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      // Now in CLEAR; six more edges land on RUN k=5
      repeat (6) begin
         @(posedge clk); #1;
      end
      rst = 1'b0;
      #1;
      check_reset_outputs("mid_op_reset");
      @(posedge clk); #1;
      check_reset_outputs("mid_op_reset_hold");
      release_reset();
      n_checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL no_rsp_after_reset: got valid=%b busy=%b expected 0 0", rsp_valid, busy);
      end
      do_op(8'h03, 8'h05, 0, 1'b1, 1'b0, '0, '0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         do_op(W'($urandom), W'($urandom), int'($urandom_range(0, 2)), 1'b1, 1'b0, '0, '0);
      end
   endtask

`ifdef SPM_SEQ_CTRL_PERF_EN
   task automatic test_perf();
      rst = 1'b0;
      #1;
      n_checks++;
      if (op_count !== 16'd0 || stall_count !== 16'd0) begin
         n_fail++;
         $display("FAIL perf_reset: got op=%0d stall=%0d expected 0 0", op_count, stall_count);
      end
      release_reset();
      do_op(8'h12, 8'h34, 0, 1'b0, 1'b0, '0, '0);
      do_op(8'h56, 8'h78, 4, 1'b0, 1'b0, '0, '0);
      do_op(8'h9A, 8'hBC, 0, 1'b0, 1'b0, '0, '0);
      n_checks++;
      if (op_count !== 16'd3 || stall_count !== 16'd4) begin
         n_fail++;
         $display("FAIL perf_counts: got op=%0d stall=%0d expected 3 4", op_count, stall_count);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_holdoff();
      test_reset_mid_op();
      test_back_to_back();
`ifdef SPM_SEQ_CTRL_PERF_EN
      test_perf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
